// File: rtl/irs_trigger_block_buffer.sv
// irs_trigger_block_buffer
//   Keeps a circular history of every block the IRS write controller reports
//   as written. On a trigger it queues the PRETRIG most recent blocks, then the
//   next POSTTRIG blocks written, into a first-word-fall-through readout FIFO.
//   Each queued entry is tagged with an end-of-event flag.
//
//   Optional feature, macro IRS_TRIGBUF_TIMESTAMP_EN:
//     A 16-bit free-running cycle counter is latched on each accepted trigger.
//     The latched value is carried in the FIFO with the first entry of the
//     event and appears on ev_time_o while that entry is at the head. All other
//     entries carry 0.
module irs_trigger_block_buffer #(
  parameter int HIST_AW  = 5,
  parameter int PRETRIG  = 4,
  parameter int POSTTRIG = 4,
  parameter int FIFO_AW  = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [8:0]  blk_i,
  input  logic        blk_ack_i,
  input  logic        trig_i,
  input  logic        rd_i,
  output logic [8:0]  rd_blk_o,
  output logic        rd_last_o,
  output logic        rd_empty_o,
  output logic        busy_o,
  output logic        trig_ign_o,
  output logic        ovf_o
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  ,
  output logic [15:0] ev_time_o
`endif
);

  localparam int HIST_DEPTH = 1 << HIST_AW;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  // Counter width: holds PRETRIG + POSTTRIG, which is at most HIST_DEPTH.
  localparam int CW = HIST_AW + 1;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  localparam int FW = 26;  // {timestamp[15:0], block[8:0], last}
`else
  localparam int FW = 10;  // {block[8:0], last}
`endif

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // History ring and its bookkeeping
  logic [8:0]         ring_q [HIST_DEPTH];
  logic [HIST_AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0]      hist_cnt_q, hist_cnt_d;

  // Event state
  state_t             state_q, state_d;
  logic [HIST_AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [CW-1:0]      pre;
  logic               trig_ign_q, trig_ign_d;
  logic               ovf_q, ovf_d;

  // Readout FIFO
  logic [FW-1:0]      fifo_q [FIFO_DEPTH];
  logic [FIFO_AW:0]   fwr_q, fwr_d, frd_q, frd_d, fcnt_q, fcnt_d;
  logic [FW-1:0]      head_q, head_d;
  logic               empty_q, empty_d;
  logic               fifo_full;
  logic               push, pop;
  logic [FW-1:0]      push_data;

`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  logic [15:0]        ts_q, ts_d;
  logic [15:0]        ev_ts_q, ev_ts_d;
  logic               first_q, first_d;
`endif

  // History pointer and saturating count of blocks available as pre-trigger
  always_comb begin
    wptr_d     = wptr_q;
    hist_cnt_d = hist_cnt_q;
    if (blk_ack_i) begin
      wptr_d = wptr_q + 1'b1;
      if (hist_cnt_q != CW'(PRETRIG)) hist_cnt_d = hist_cnt_q + 1'b1;
    end
  end

  // Ring storage; recording never pauses, whatever the event state
  // NOTE: storage arrays carry no reset; validity is tracked by pointers and
  // counts, which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (blk_ack_i) ring_q[wptr_q] <= blk_i;
  end

  assign fifo_full = (fcnt_q == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign pop       = rd_i && (fcnt_q != '0);

`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  assign push_data = {(first_q ? ev_ts_q : 16'h0000), ring_q[rptr_q], (rem_q == CW'(1))};
`else
  assign push_data = {ring_q[rptr_q], (rem_q == CW'(1))};
`endif

  // Event sequencing: trigger capture, ordered emission and overrun detection
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    rem_d      = rem_q;
    trig_ign_d = 1'b0;
    ovf_d      = ovf_q;
    push       = 1'b0;
    // A same-cycle ack is already folded into hist_cnt_d, so that block
    // becomes the newest pre-trigger entry.
    pre        = hist_cnt_d;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
    ev_ts_d    = ev_ts_q;
    first_d    = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (trig_i) begin
          rptr_d  = wptr_d - pre[HIST_AW-1:0];
          rem_d   = pre + CW'(POSTTRIG);
          state_d = EMIT;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
          ev_ts_d = ts_q;
          first_d = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (trig_i) trig_ign_d = 1'b1;
        if ((rptr_q != wptr_q) && !fifo_full) begin
          push   = 1'b1;
          rptr_d = rptr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == CW'(1)) state_d = IDLE;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
          first_d = 1'b0;
`endif
        end
        // The writer is about to land on the oldest block still owed to
        // the event: flag it, but keep going with whatever is there.
        if (blk_ack_i && (wptr_d == rptr_d)) ovf_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and the registered head word presented to the reader
  always_comb begin
    fwr_d  = fwr_q;
    frd_d  = frd_q;
    fcnt_d = fcnt_q;
    if (push) fwr_d = fwr_q + 1'b1;
    if (pop)  frd_d = frd_q + 1'b1;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop) fcnt_d = fcnt_q - 1'b1;
    empty_d = (fcnt_d == '0);
    head_d  = '0;
    if (!empty_d) begin
      // The new head may be the word being written this cycle.
      if (push && (fwr_q == frd_d)) head_d = push_data;
      else                          head_d = fifo_q[frd_d[FIFO_AW-1:0]];
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[fwr_q[FIFO_AW-1:0]] <= push_data;
  end

`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  // Free-running cycle counter, wraps naturally at 16 bits
  always_comb ts_d = ts_q + 16'd1;
`endif

  // All control state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      hist_cnt_q <= '0;
      state_q    <= IDLE;
      rptr_q     <= '0;
      rem_q      <= '0;
      trig_ign_q <= 1'b0;
      ovf_q      <= 1'b0;
      fwr_q      <= '0;
      frd_q      <= '0;
      fcnt_q     <= '0;
      head_q     <= '0;
      empty_q    <= 1'b1;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
      ts_q       <= '0;
      ev_ts_q    <= '0;
      first_q    <= 1'b0;
`endif
    end else begin
      wptr_q     <= wptr_d;
      hist_cnt_q <= hist_cnt_d;
      state_q    <= state_d;
      rptr_q     <= rptr_d;
      rem_q      <= rem_d;
      trig_ign_q <= trig_ign_d;
      ovf_q      <= ovf_d;
      fwr_q      <= fwr_d;
      frd_q      <= frd_d;
      fcnt_q     <= fcnt_d;
      head_q     <= head_d;
      empty_q    <= empty_d;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
      ts_q       <= ts_d;
      ev_ts_q    <= ev_ts_d;
      first_q    <= first_d;
`endif
    end
  end

  assign rd_blk_o   = head_q[9:1];
  assign rd_last_o  = head_q[0];
  assign rd_empty_o = empty_q;
  assign busy_o     = (state_q == EMIT);
  assign trig_ign_o = trig_ign_q;
  assign ovf_o      = ovf_q;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  assign ev_time_o  = head_q[25:10];
`endif

endmodule

// File: tb/tb_irs_trigger_block_buffer.sv
// Directed bench for irs_trigger_block_buffer. Three instances share stimulus:
//   u0 default geometry, u1 with a 4-entry FIFO, u2 with an 8-entry ring and
//   4-entry FIFO. Every scenario starts from reset and inspects the instance
//   it targets. Outputs are sampled 1 time unit after the rising edge.
module tb_irs_trigger_block_buffer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [8:0] blk_i = '0;
  logic       blk_ack_i = 1'b0;
  logic       trig_i = 1'b0;
  logic       rd_i = 1'b0;

  logic [8:0] blk0, blk1, blk2;
  logic       last0, last1, last2;
  logic       emp0, emp1, emp2;
  logic       busy0, busy1, busy2;
  logic       ign0, ign1, ign2;
  logic       ovf0, ovf1, ovf2;
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
  logic [15:0] ts0, ts1, ts2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int got_blk[$];
  int got_last[$];

  always #5 clk_i = ~clk_i;

  irs_trigger_block_buffer #(.HIST_AW(5), .PRETRIG(4), .POSTTRIG(4), .FIFO_AW(6)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .blk_i(blk_i), .blk_ack_i(blk_ack_i), .trig_i(trig_i),
    .rd_i(rd_i), .rd_blk_o(blk0), .rd_last_o(last0), .rd_empty_o(emp0), .busy_o(busy0),
    .trig_ign_o(ign0), .ovf_o(ovf0)
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
    , .ev_time_o(ts0)
`endif
  );

  irs_trigger_block_buffer #(.HIST_AW(5), .PRETRIG(4), .POSTTRIG(4), .FIFO_AW(2)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .blk_i(blk_i), .blk_ack_i(blk_ack_i), .trig_i(trig_i),
    .rd_i(rd_i), .rd_blk_o(blk1), .rd_last_o(last1), .rd_empty_o(emp1), .busy_o(busy1),
    .trig_ign_o(ign1), .ovf_o(ovf1)
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
    , .ev_time_o(ts1)
`endif
  );

  irs_trigger_block_buffer #(.HIST_AW(3), .PRETRIG(4), .POSTTRIG(4), .FIFO_AW(2)) u2 (
    .clk_i(clk_i), .rst_i(rst_i), .blk_i(blk_i), .blk_ack_i(blk_ack_i), .trig_i(trig_i),
    .rd_i(rd_i), .rd_blk_o(blk2), .rd_last_o(last2), .rd_empty_o(emp2), .busy_o(busy2),
    .trig_ign_o(ign2), .ovf_o(ovf2)
`ifdef IRS_TRIGBUF_TIMESTAMP_EN
    , .ev_time_o(ts2)
`endif
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    blk_ack_i = 1'b0;
    trig_i    = 1'b0;
    rd_i      = 1'b0;
    blk_i     = '0;
    rst_i     = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic ack(input int b);
    blk_i     = 9'(b);
    blk_ack_i = 1'b1;
    step();
    blk_ack_i = 1'b0;
  endtask

  task automatic trig();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
  endtask

  // Pops everything that shows up on the chosen instance for a fixed number
  // of cycles and records it in got_blk/got_last.
  task automatic collect(input int which, input int cycles);
    logic       e;
    logic [8:0] b;
    logic       l;
    got_blk.delete();
    got_last.delete();
    for (int c = 0; c < cycles; c++) begin
      case (which)
        0:       begin e = emp0; b = blk0; l = last0; end
        1:       begin e = emp1; b = blk1; l = last1; end
        default: begin e = emp2; b = blk2; l = last2; end
      endcase
      if (!e) begin
        got_blk.push_back(int'(b));
        got_last.push_back(int'(l));
        rd_i = 1'b1;
      end else begin
        rd_i = 1'b0;
      end
      step();
    end
    rd_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (emp0 !== 1'b1)  begin n_fail++; $display("FAIL reset_empty got %b want 1", emp0); end
    n_checks++; if (blk0 !== 9'd0)  begin n_fail++; $display("FAIL reset_blk got %0d want 0", blk0); end
    n_checks++; if (last0 !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", last0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_checks++; if (ign0 !== 1'b0)  begin n_fail++; $display("FAIL reset_ign got %b want 0", ign0); end
    n_checks++; if (ovf0 !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf0); end
  endtask

  task automatic test_warmup();
    int exp_blk[8] = '{12, 13, 14, 15, 16, 17, 18, 19};
    do_reset();
    for (int b = 10; b <= 15; b++) begin
      ack(b);
      step(); step(); step();
    end
    trig();
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL warm_busy_start got %b want 1", busy0); end
    step(); step(); step(); step();
    n_checks++; if (emp0 !== 1'b0 || blk0 !== 9'd12)
      begin n_fail++; $display("FAIL warm_head_pre got empty=%b blk=%0d want empty=0 blk=12", emp0, blk0); end
    for (int b = 16; b <= 18; b++) begin
      ack(b);
      step(); step(); step();
    end
    ack(19);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL warm_busy_before_last got %b want 1", busy0); end
    step();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL warm_busy_after_last got %b want 0", busy0); end
    collect(0, 12);
    n_checks++; if (got_blk.size() != 8) begin n_fail++; $display("FAIL warm_count got %0d want 8", got_blk.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_blk.size() || got_blk[i] != exp_blk[i] || got_last[i] != int'(i == 7)) begin
        n_fail++;
        $display("FAIL warm_entry[%0d] got blk=%0d last=%0d want blk=%0d last=%0d", i,
                 (i < got_blk.size()) ? got_blk[i] : -1, (i < got_last.size()) ? got_last[i] : -1,
                 exp_blk[i], int'(i == 7));
      end
    end
  endtask

  task automatic test_cold();
    int exp_blk[4] = '{100, 101, 102, 103};
    do_reset();
    trig();
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL cold_busy got %b want 1", busy0); end
    step(); step();
    n_checks++; if (emp0 !== 1'b1) begin n_fail++; $display("FAIL cold_no_pre got empty=%b want 1", emp0); end
    for (int b = 100; b <= 103; b++) begin
      ack(b);
      step();
    end
    step(); step();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL cold_busy_end got %b want 0", busy0); end
    collect(0, 8);
    n_checks++; if (got_blk.size() != 4) begin n_fail++; $display("FAIL cold_count got %0d want 4", got_blk.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_blk.size() || got_blk[i] != exp_blk[i] || got_last[i] != int'(i == 3)) begin
        n_fail++;
        $display("FAIL cold_entry[%0d] got blk=%0d want blk=%0d last=%0d", i,
                 (i < got_blk.size()) ? got_blk[i] : -1, exp_blk[i], int'(i == 3));
      end
    end
  endtask

  task automatic test_retrigger();
    int exp_blk[8] = '{3, 4, 5, 6, 20, 21, 22, 23};
    do_reset();
    for (int b = 1; b <= 6; b++) ack(b);
    trig();
    n_checks++; if (ign0 !== 1'b0) begin n_fail++; $display("FAIL retrig_ign_first got %b want 0", ign0); end
    trig();
    n_checks++; if (ign0 !== 1'b1) begin n_fail++; $display("FAIL retrig_ign_pulse got %b want 1", ign0); end
    step();
    n_checks++; if (ign0 !== 1'b0) begin n_fail++; $display("FAIL retrig_ign_width got %b want 0", ign0); end
    for (int b = 20; b <= 23; b++) ack(b);
    step(); step(); step();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL retrig_busy_end got %b want 0", busy0); end
    collect(0, 12);
    n_checks++; if (got_blk.size() != 8) begin n_fail++; $display("FAIL retrig_count got %0d want 8", got_blk.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_blk.size() || got_blk[i] != exp_blk[i] || got_last[i] != int'(i == 7)) begin
        n_fail++;
        $display("FAIL retrig_entry[%0d] got blk=%0d want blk=%0d", i,
                 (i < got_blk.size()) ? got_blk[i] : -1, exp_blk[i]);
      end
    end
  endtask

  task automatic test_same_cycle_ack();
    int exp_blk[8] = '{4, 5, 6, 7, 8, 9, 10, 11};
    do_reset();
    for (int b = 4; b <= 6; b++) ack(b);
    blk_i     = 9'd7;
    blk_ack_i = 1'b1;
    trig_i    = 1'b1;
    step();
    blk_ack_i = 1'b0;
    trig_i    = 1'b0;
    for (int b = 8; b <= 11; b++) ack(b);
    step(); step(); step();
    collect(0, 12);
    n_checks++; if (got_blk.size() != 8) begin n_fail++; $display("FAIL same_count got %0d want 8", got_blk.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_blk.size() || got_blk[i] != exp_blk[i] || got_last[i] != int'(i == 7)) begin
        n_fail++;
        $display("FAIL same_entry[%0d] got blk=%0d want blk=%0d", i,
                 (i < got_blk.size()) ? got_blk[i] : -1, exp_blk[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_blk[8] = '{3, 4, 5, 6, 7, 8, 9, 10};
    do_reset();
    for (int b = 1; b <= 6; b++) ack(b);
    trig();
    for (int b = 7; b <= 10; b++) ack(b);
    repeat (10) step();
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL bp_stalled_busy got %b want 1", busy1); end
    n_checks++; if (ovf1 !== 1'b0)  begin n_fail++; $display("FAIL bp_ovf got %b want 0", ovf1); end
    n_checks++; if (emp1 !== 1'b0 || blk1 !== 9'd3)
      begin n_fail++; $display("FAIL bp_head got empty=%b blk=%0d want empty=0 blk=3", emp1, blk1); end
    collect(1, 30);
    n_checks++; if (got_blk.size() != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", got_blk.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_blk.size() || got_blk[i] != exp_blk[i] || got_last[i] != int'(i == 7)) begin
        n_fail++;
        $display("FAIL bp_entry[%0d] got blk=%0d want blk=%0d", i,
                 (i < got_blk.size()) ? got_blk[i] : -1, exp_blk[i]);
      end
    end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got %b want 0", busy1); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int b = 1; b <= 4; b++) ack(b);
    trig();
    repeat (6) step();
    n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovr_before got %b want 0", ovf2); end
    for (int b = 5; b <= 11; b++) ack(b);
    n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovr_seven_acks got %b want 0", ovf2); end
    ack(12);
    n_checks++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovr_eighth_ack got %b want 1", ovf2); end
    collect(2, 10);
    n_checks++; if (got_blk.size() < 1 || got_blk[0] != 1)
      begin n_fail++; $display("FAIL ovr_first_entry got %0d want 1", (got_blk.size() > 0) ? got_blk[0] : -1); end
    ack(13);
    repeat (5) step();
    n_checks++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", ovf2); end
    do_reset();
    n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared got %b want 0", ovf2); end
  endtask

  task automatic test_async_reset();
    int exp_blk[4] = '{50, 51, 52, 53};
    do_reset();
    for (int b = 1; b <= 3; b++) ack(b);
    trig();
    step(); step();
    n_checks++; if (busy0 !== 1'b1 || emp0 !== 1'b0)
      begin n_fail++; $display("FAIL arst_pre_state got busy=%b empty=%b want busy=1 empty=0", busy0, emp0); end
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (emp0 !== 1'b1)  begin n_fail++; $display("FAIL arst_empty got %b want 1", emp0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy0); end
    n_checks++; if (blk0 !== 9'd0)  begin n_fail++; $display("FAIL arst_blk got %0d want 0", blk0); end
    rst_i = 1'b0;
    step();
    trig();
    for (int b = 50; b <= 53; b++) ack(b);
    step(); step(); step();
    collect(0, 8);
    n_checks++; if (got_blk.size() != 4) begin n_fail++; $display("FAIL arst_count got %0d want 4", got_blk.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_blk.size() || got_blk[i] != exp_blk[i] || got_last[i] != int'(i == 3)) begin
        n_fail++;
        $display("FAIL arst_entry[%0d] got blk=%0d want blk=%0d", i,
                 (i < got_blk.size()) ? got_blk[i] : -1, exp_blk[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_cold();
    test_retrigger();
    test_same_cycle_ack();
    test_backpressure();
    test_overrun();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
